// File: rtl/sysid_boot_checker.sv
// Post-reset sequencer: reads the sysid slave (addr 0 = ID, addr 1 = timestamp), compares, retries.
// Optional response timeout in *_WAIT states is enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h5AAA_07C9,
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned RETRY_GAP   = 16,
  parameter bit          AUTO_START  = 1'b1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  attempts
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ID_REQ  = 3'd1;
  localparam logic [2:0] S_ID_WAIT = 3'd2;
  localparam logic [2:0] S_TS_REQ  = 3'd3;
  localparam logic [2:0] S_TS_WAIT = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_GAP     = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [4:0] RETRY_LIMIT = 5'(MAX_RETRIES);
  localparam logic [7:0] GAP_LAST    = 8'(RETRY_GAP - 1);

  if (MAX_RETRIES > 15 || RETRY_GAP < 1 || RETRY_GAP > 255 || TIMEOUT < 1 || TIMEOUT > 255) begin : gBadParams
    $error("sysid_boot_checker: parameter out of range");
  end

  logic [2:0]  state_q, state_d;
  logic        autoPend_q, autoPend_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [31:0] idValue_q, idValue_d;
  logic [31:0] tsValue_q, tsValue_d;
  logic [3:0]  attempts_q, attempts_d;
  logic [7:0]  gapCnt_q, gapCnt_d;
  logic [4:0]  nextAttempt;
  logic        attemptOk;
  logic        launch;

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmoCnt_q, tmoCnt_d;
  logic       timedOut_q, timedOut_d;
`endif

  always_comb begin
    state_d     = state_q;
    autoPend_d  = autoPend_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    idValue_d   = idValue_q;
    tsValue_d   = tsValue_q;
    attempts_d  = attempts_q;
    gapCnt_d    = gapCnt_q;
    launch      = 1'b0;
    nextAttempt = {1'b0, attempts_q} + 5'd1;
    attemptOk   = (idValue_q == EXPECTED_ID) && (tsValue_q == EXPECTED_TS);
`ifdef SYSID_CHECK_TIMEOUT_EN
    tmoCnt_d    = tmoCnt_q;
    timedOut_d  = timedOut_q;
    if (timedOut_q) attemptOk = 1'b0;
`endif

    case (state_q)
      S_IDLE: launch = start || autoPend_q;
      S_ID_REQ: begin
`ifdef SYSID_CHECK_TIMEOUT_EN
        tmoCnt_d = 8'd0;
`endif
        if (!avm_waitrequest) state_d = S_ID_WAIT;
      end
      S_ID_WAIT: begin
        if (avm_readdatavalid) begin
          idValue_d = avm_readdata;
          state_d   = S_TS_REQ;
        end
`ifdef SYSID_CHECK_TIMEOUT_EN
        else if (tmoCnt_q == TMO_LAST) begin
          timedOut_d = 1'b1;
          state_d    = S_CHECK;
        end else begin
          tmoCnt_d = tmoCnt_q + 8'd1;
        end
`endif
      end
      S_TS_REQ: begin
`ifdef SYSID_CHECK_TIMEOUT_EN
        tmoCnt_d = 8'd0;
`endif
        if (!avm_waitrequest) state_d = S_TS_WAIT;
      end
      S_TS_WAIT: begin
        if (avm_readdatavalid) begin
          tsValue_d = avm_readdata;
          state_d   = S_CHECK;
        end
`ifdef SYSID_CHECK_TIMEOUT_EN
        else if (tmoCnt_q == TMO_LAST) begin
          timedOut_d = 1'b1;
          state_d    = S_CHECK;
        end else begin
          tmoCnt_d = tmoCnt_q + 8'd1;
        end
`endif
      end
      S_CHECK: begin
        // The retry decision uses an unsaturated 5-bit count so MAX_RETRIES=15 still terminates.
        attempts_d = (attempts_q == 4'hF) ? 4'hF : attempts_q + 4'd1;
        if (attemptOk) begin
          pass_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (nextAttempt <= RETRY_LIMIT) begin
          gapCnt_d = 8'd0;
          state_d  = S_GAP;
        end else begin
          fail_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          state_d = S_ID_REQ;
`ifdef SYSID_CHECK_TIMEOUT_EN
          timedOut_d = 1'b0;
`endif
        end else begin
          gapCnt_d = gapCnt_q + 8'd1;
        end
      end
      S_DONE: launch = start;
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d    = S_ID_REQ;
      autoPend_d = 1'b0;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      attempts_d = 4'd0;
`ifdef SYSID_CHECK_TIMEOUT_EN
      timedOut_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      autoPend_q <= AUTO_START;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      idValue_q  <= 32'd0;
      tsValue_q  <= 32'd0;
      attempts_q <= 4'd0;
      gapCnt_q   <= 8'd0;
`ifdef SYSID_CHECK_TIMEOUT_EN
      tmoCnt_q   <= 8'd0;
      timedOut_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      autoPend_q <= autoPend_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      idValue_q  <= idValue_d;
      tsValue_q  <= tsValue_d;
      attempts_q <= attempts_d;
      gapCnt_q   <= gapCnt_d;
`ifdef SYSID_CHECK_TIMEOUT_EN
      tmoCnt_q   <= tmoCnt_d;
      timedOut_q <= timedOut_d;
`endif
    end
  end

  assign avm_read    = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
  assign avm_address = (state_q == S_TS_REQ);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign id_value    = idValue_q;
  assign ts_value    = tsValue_q;
  assign attempts    = attempts_q;

endmodule
